// File: rtl/generic_bram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : generic_bram_sdp
// Description : Simple-dual-port block RAM with one write port, one read port
//               and one clock. Registered read output, 1-cycle latency,
//               read-before-write on a same-address collision.
// Revision    : 1.0 - initial release
// ============================================================================
module generic_bram_sdp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  rden,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic [DATA_WIDTH-1:0] data
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // The array has no reset so it maps onto block RAM; the declaration
    // initialiser provides the power-up zero contents.
    (* ramstyle = "M9K" *) logic [DATA_WIDTH-1:0] r_mem [c_DEPTH] = '{default: '0};

    // Writes are suppressed while aclr is held low.
    always_ff @(posedge clock) begin
        if (aclr && wren) begin
            r_mem[wraddress] <= data;
        end
    end

    // Sampling the array on the write edge yields the old word on a collision.
    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            q <= '0;
        end else if (rden) begin
            q <= r_mem[rdaddress];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_generic_bram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : tb_generic_bram_sdp
// Description : Self-checking bench for generic_bram_sdp against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_generic_bram_sdp;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;
    localparam int c_DEPTH    = 1 << ADDR_WIDTH;

    logic                  clock = 1'b0;
    logic                  aclr  = 1'b1;
    logic                  rden  = 1'b0;
    logic [ADDR_WIDTH-1:0] rdaddress = '0;
    logic [DATA_WIDTH-1:0] q;
    logic                  wren  = 1'b0;
    logic [ADDR_WIDTH-1:0] wraddress = '0;
    logic [DATA_WIDTH-1:0] data  = '0;

    logic [DATA_WIDTH-1:0] model [c_DEPTH];
    logic [DATA_WIDTH-1:0] exp_q = '0;
    int n_pass  = 0;
    int n_total = 0;

    generic_bram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clock     (clock),
        .aclr      (aclr),
        .rden      (rden),
        .rdaddress (rdaddress),
        .q         (q),
        .wren      (wren),
        .wraddress (wraddress),
        .data      (data)
    );

    initial forever #5 clock = ~clock;

    // Advance one rising edge; the model reads before it writes.
    task automatic step();
        if (aclr) begin
            if (rden) exp_q = model[rdaddress];
            if (wren) model[wraddress] = data;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1 aclr = 1'b0;
        #1;
        n_total++;
        if (q !== '0) $display("FAIL reset_initial q=%h exp=%h", q, 32'h0); else n_pass++;
        #20 aclr = 1'b1;
        @(posedge clock);
        #1;
        wren = 1'b1; wraddress = 8'd10; data = 32'hA5;
        step();
        wren = 1'b0; rden = 1'b1; rdaddress = 8'd10;
        step();
        n_total++;
        if (q !== 32'hA5) $display("FAIL reset_preload q=%h exp=%h", q, 32'hA5); else n_pass++;
        rden = 1'b0;
        #2 aclr = 1'b0;
        #1;
        n_total++;
        if (q !== '0) $display("FAIL reset_async q=%h exp=%h", q, 32'h0); else n_pass++;
        @(posedge clock);
        #1;
        rden = 1'b1; rdaddress = 8'd10;
        step();
        n_total++;
        if (q !== '0) $display("FAIL reset_hold q=%h exp=%h", q, 32'h0); else n_pass++;
        exp_q = '0;
        aclr = 1'b1;
        rden = 1'b1; rdaddress = 8'd3;
        step();
        n_total++;
        if (q !== '0) $display("FAIL reset_powerup_zero q=%h exp=%h", q, 32'h0); else n_pass++;
        rden = 1'b0;
    endtask

    task automatic test_write_read();
        wren = 1'b1; wraddress = 8'd5; data = 32'h1234;
        step();
        wren = 1'b0; rden = 1'b1; rdaddress = 8'd5;
        step();
        n_total++;
        if (q !== 32'h1234) $display("FAIL write_read q=%h exp=%h", q, 32'h1234); else n_pass++;
        rden = 1'b0;
    endtask

    task automatic test_collision();
        wren = 1'b1; wraddress = 8'd7; data = 32'h11;
        step();
        wren = 1'b1; wraddress = 8'd7; data = 32'h22;
        rden = 1'b1; rdaddress = 8'd7;
        step();
        n_total++;
        if (q !== 32'h11) $display("FAIL collision_old q=%h exp=%h", q, 32'h11); else n_pass++;
        wren = 1'b0;
        step();
        n_total++;
        if (q !== 32'h22) $display("FAIL collision_new q=%h exp=%h", q, 32'h22); else n_pass++;
        rden = 1'b0;
    endtask

    task automatic test_hold();
        wren = 1'b1; wraddress = 8'd2; data = 32'h55;
        step();
        wren = 1'b0; rden = 1'b1; rdaddress = 8'd2;
        step();
        n_total++;
        if (q !== 32'h55) $display("FAIL hold_load q=%h exp=%h", q, 32'h55); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            rden = 1'b0; rdaddress = ADDR_WIDTH'($urandom);
            wren = 1'b1; wraddress = 8'd2; data = $urandom;
            step();
            n_total++;
            if (q !== 32'h55) $display("FAIL hold_cycle%0d q=%h exp=%h", i, q, 32'h55); else n_pass++;
        end
        wren = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DATA_WIDTH-1:0] expv;
        wren = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) begin
            wraddress = ADDR_WIDTH'(i);
            data = DATA_WIDTH'(i) ^ 32'h3C;
            step();
        end
        wren = 1'b0; rden = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) begin
            rdaddress = ADDR_WIDTH'(i);
            step();
            expv = DATA_WIDTH'(i) ^ 32'h3C;
            n_total++;
            if (q !== expv) $display("FAIL b2b_addr%0d q=%h exp=%h", i, q, expv); else n_pass++;
        end
        rden = 1'b0;
    endtask

    task automatic test_mid_reset();
        rden = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdaddress = ADDR_WIDTH'($urandom);
            step();
            n_total++;
            if (q !== exp_q) $display("FAIL midrst_stream%0d q=%h exp=%h", i, q, exp_q); else n_pass++;
        end
        rdaddress = 8'd9;
        #1 aclr = 1'b0;
        wren = 1'b1; wraddress = 8'd0; data = 32'hDEADBEEF;
        #1;
        n_total++;
        if (q !== '0) $display("FAIL midrst_async q=%h exp=%h", q, 32'h0); else n_pass++;
        step();
        n_total++;
        if (q !== '0) $display("FAIL midrst_hold q=%h exp=%h", q, 32'h0); else n_pass++;
        exp_q = '0;
        aclr = 1'b1; wren = 1'b0;
        rdaddress = 8'd0;
        step();
        n_total++;
        if (q !== 32'h3C) $display("FAIL midrst_keep0 q=%h exp=%h", q, 32'h3C); else n_pass++;
        rdaddress = 8'd255;
        step();
        n_total++;
        if (q !== 32'hC3) $display("FAIL midrst_keep255 q=%h exp=%h", q, 32'hC3); else n_pass++;
        rden = 1'b0;
    endtask

    // Narrow address window so collisions and holds occur often.
    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rden = 1'($urandom);
            wren = 1'($urandom);
            rdaddress = ADDR_WIDTH'($urandom_range(0, 7));
            wraddress = ADDR_WIDTH'($urandom_range(0, 7));
            data = $urandom;
            step();
            n_total++;
            if (q !== exp_q) $display("FAIL random_cycle%0d q=%h exp=%h", i, q, exp_q); else n_pass++;
        end
        rden = 1'b0; wren = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < c_DEPTH; i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_collision();
        test_hold();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
